// File: rtl/deb_count_n_pkg.sv
// Shared constants for the debounced trigger counter: edge-mode encodings,
// default parameter values and the edge-selection helper.
package deb_count_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEB_CYCLES = 16;
    localparam int DEF_EDGE_MODE  = 0;

    function automatic logic edge_sel(input edge_mode_e mode, input logic rise, input logic fall);
        logic sel;
        case (mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            EDGE_BOTH: sel = rise | fall;
            default:   sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/deb_count_n_filter.sv
// Per-channel front end: 2-flop synchronizer, debounce run counter, stable
// level and a registered one-cycle strobe on the selected level transition.
module deb_filter
    import deb_count_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int EDGE_MODE  = DEF_EDGE_MODE
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    output logic level,
    output logic pulse
);

    localparam int               RUN_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYCLES - 1);
    localparam edge_mode_e       MODE     = edge_mode_e'(EDGE_MODE);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_pulse;
    logic [RUN_W-1:0] r_run;
    logic             w_rise;
    logic             w_fall;

    assign w_rise = r_level & ~r_level_d;
    assign w_fall = ~r_level & r_level_d;

    // Synchronize, debounce and strobe; the level only flips once the run of
    // differing samples reaches DEB_CYCLES.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
            r_run     <= '0;
        end else begin
            r_sync1   <= trigger;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_pulse   <= edge_sel(MODE, w_rise, w_fall);
            if (r_sync2 == r_level) begin
                r_run <= '0;
            end else if (r_run == RUN_LAST) begin
                r_level <= ~r_level;
                r_run   <= '0;
            end else begin
                r_run <= r_run + RUN_W'(1);
            end
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: rtl/deb_count_n.sv
// Multi-channel debounced edge counter with sticky overflow per channel.
// DEB_COUNT_N_SAT_EN: counts saturate at max instead of wrapping.
module deb_count_n
    import deb_count_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int EDGE_MODE  = DEF_EDGE_MODE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         trigger,
    input  logic                    en,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         pulse,
    output logic [N_CH-1:0]         ovf
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_pulse;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic             r_ovf;

        deb_filter #(
            .DEB_CYCLES (DEB_CYCLES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_filter (
            .clock   (clock),
            .reset   (reset),
            .trigger (trigger[g]),
            .level   (w_level[g]),
            .pulse   (w_pulse[g])
        );

        // Count accepted edges; clear beats a coincident increment.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (clr[g]) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_pulse[g] && en) begin
                if (r_count == CNT_MAX) begin
                    r_ovf <= 1'b1;
`ifdef DEB_COUNT_N_SAT_EN
                    r_count <= r_count;
`else
                    r_count <= '0;
`endif
                end else begin
                    r_count <= r_count + WIDTH'(1);
                end
            end else begin
                r_count <= r_count;
                r_ovf   <= r_ovf;
            end
        end

        assign count[g*WIDTH +: WIDTH] = r_count;
        assign ovf[g]                  = r_ovf;
    end

    assign level = w_level;
    assign pulse = w_pulse;

endmodule

// File: tb/tb_deb_count_n.sv
// Scoreboard bench for deb_count_n: expectations are queued at stimulus time
// and checked by a monitor one cycle after each pulse strobe.
module tb_deb_count_n;

    typedef struct {
        int          inst;
        int          ch;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 channels, 2-bit counts, rising edges, DEB_CYCLES=4
    logic       rst_a;
    logic [3:0] trig_a;
    logic       en_a;
    logic [3:0] clr_a;
    logic [7:0] count_a;
    logic [3:0] level_a, pulse_a, ovf_a;

    // Instances B (both edges) and C (falling) share stimulus
    logic       rst_bc;
    logic [0:0] trig_bc;
    logic       en_bc;
    logic [0:0] clr_bc;
    logic [7:0] count_b, count_c;
    logic [0:0] level_b, pulse_b, ovf_b, level_c, pulse_c, ovf_c;

    deb_count_n #(.N_CH(4), .WIDTH(2), .DEB_CYCLES(4), .EDGE_MODE(0)) u_a (
        .clock(clk), .reset(rst_a), .trigger(trig_a), .en(en_a), .clr(clr_a),
        .count(count_a), .level(level_a), .pulse(pulse_a), .ovf(ovf_a));

    deb_count_n #(.N_CH(1), .WIDTH(8), .DEB_CYCLES(4), .EDGE_MODE(2)) u_b (
        .clock(clk), .reset(rst_bc), .trigger(trig_bc), .en(en_bc), .clr(clr_bc),
        .count(count_b), .level(level_b), .pulse(pulse_b), .ovf(ovf_b));

    deb_count_n #(.N_CH(1), .WIDTH(8), .DEB_CYCLES(4), .EDGE_MODE(1)) u_c (
        .clock(clk), .reset(rst_bc), .trigger(trig_bc), .en(en_bc), .clr(clr_bc),
        .count(count_c), .level(level_c), .pulse(pulse_c), .ovf(ovf_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input int inst, input int ch, input int cnt, input logic ovf);
        exp_t e;
        e.inst = inst;
        e.ch   = ch;
        e.cnt  = 32'(cnt);
        e.ovf  = ovf;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input int inst, input int ch, input logic [31:0] act_cnt, input logic act_ovf);
        int idx;
        idx = -1;
        for (int k = 0; k < sbq.size(); k++) begin
            if (idx < 0 && sbq[k].inst == inst && sbq[k].ch == ch) idx = k;
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_pulse inst=%0d ch=%0d actual=pulse required=none", inst, ch);
        end else begin
            chk($sformatf("sb_count_i%0d_c%0d", inst, ch), act_cnt, sbq[idx].cnt);
            chk($sformatf("sb_ovf_i%0d_c%0d", inst, ch), 32'(act_ovf), 32'(sbq[idx].ovf));
            sbq.delete(idx);
        end
    endtask

    // Monitor: the cycle after a strobe the count must match the queued value
    logic [3:0] pa_d = 4'd0;
    logic       pb_d = 1'b0;
    logic       pc_d = 1'b0;
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (pa_d[c]) sb_check(0, c, 32'(count_a[c*2 +: 2]), ovf_a[c]);
        end
        if (pb_d) sb_check(1, 0, 32'(count_b), ovf_b[0]);
        if (pc_d) sb_check(2, 0, 32'(count_c), ovf_c[0]);
        pa_d <= pulse_a;
        pb_d <= pulse_b[0];
        pc_d <= pulse_c[0];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ch(input int ch);
        trig_a[ch] = 1'b1;
        tick(10);
        trig_a[ch] = 1'b0;
        tick(10);
    endtask

    int wrap_cnt[5];
    int wrap_ovf[5];

    initial begin
`ifdef DEB_COUNT_N_SAT_EN
        wrap_cnt = '{1, 2, 3, 3, 3};
`else
        wrap_cnt = '{1, 2, 3, 0, 1};
`endif
        wrap_ovf = '{0, 0, 0, 1, 1};

        rst_a = 1'b1; trig_a = 4'd0; en_a = 1'b1; clr_a = 4'd0;
        rst_bc = 1'b1; trig_bc = 1'b0; en_bc = 1'b1; clr_bc = 1'b0;
        tick(3);
        rst_a = 1'b0; rst_bc = 1'b0;
        tick(1);
        chk("reset_count", 32'(count_a), 32'd0);
        chk("reset_level", 32'(level_a), 32'd0);
        chk("reset_pulse", 32'(pulse_a), 32'd0);
        chk("reset_ovf",   32'(ovf_a),   32'd0);

        // Both-edge and falling-edge counting over 5 clean periods
        for (int i = 1; i <= 5; i++) begin
            trig_bc = 1'b1;
            push(1, 0, 2 * i - 1, 1'b0);
            tick(50);
            trig_bc = 1'b0;
            push(1, 0, 2 * i, 1'b0);
            push(2, 0, i, 1'b0);
            tick(50);
        end
        chk("both_edges_count", 32'(count_b), 32'd10);
        chk("fall_edge_count",  32'(count_c), 32'd5);

        // Bounce rejection on ch0 then a clean hold
        for (int i = 0; i < 10; i++) begin
            trig_a[0] = 1'b1; tick(2);
            trig_a[0] = 1'b0; tick(2);
        end
        chk("bounce_level", 32'(level_a[0]), 32'd0);
        chk("bounce_count", 32'(count_a[1:0]), 32'd0);
        trig_a[0] = 1'b1;
        push(0, 0, 1, 1'b0);
        tick(7);
        chk("hold_level_e6", 32'(level_a[0]), 32'd1);
        chk("hold_pulse_e6", 32'(pulse_a[0]), 32'd1);
        chk("hold_count_e6", 32'(count_a[1:0]), 32'd0);
        tick(1);
        chk("hold_count_e7", 32'(count_a[1:0]), 32'd1);
        trig_a[0] = 1'b0;
        tick(10);

        // Wrap or saturation on ch2
        for (int i = 0; i < 5; i++) begin
            push(0, 2, wrap_cnt[i], wrap_ovf[i][0]);
            pulse_ch(2);
        end
        chk("wrap_count", 32'(count_a[5:4]), 32'(wrap_cnt[4]));
        chk("wrap_ovf",   32'(ovf_a[2]), 32'd1);

        // Clear on ch1 collides with its increment; ch3 counts alongside
        trig_a[1] = 1'b1;
        trig_a[3] = 1'b1;
        push(0, 1, 0, 1'b0);
        push(0, 3, 1, 1'b0);
        tick(7);
        clr_a[1] = 1'b1;
        tick(1);
        clr_a[1] = 1'b0;
        chk("collide_count1", 32'(count_a[3:2]), 32'd0);
        chk("collide_ovf1",   32'(ovf_a[1]), 32'd0);
        chk("collide_count3", 32'(count_a[7:6]), 32'd1);
        trig_a[1] = 1'b0;
        trig_a[3] = 1'b0;
        tick(10);
        chk("sticky_ovf2",  32'(ovf_a[2]), 32'd1);
        chk("keep_count2",  32'(count_a[5:4]), 32'(wrap_cnt[4]));
        clr_a[2] = 1'b1;
        tick(1);
        clr_a[2] = 1'b0;
        chk("clr_count2", 32'(count_a[5:4]), 32'd0);
        chk("clr_ovf2",   32'(ovf_a[2]), 32'd0);

        // Enable gating on ch3
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(0, 3, 1, 1'b0);
            pulse_ch(3);
        end
        chk("gated_count3", 32'(count_a[7:6]), 32'd1);
        en_a = 1'b1;
        push(0, 3, 2, 1'b0);
        pulse_ch(3);
        chk("resume_count3", 32'(count_a[7:6]), 32'd2);

        // Reset two cycles before ch0 would be accepted
        trig_a[0] = 1'b1;
        tick(3);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        chk("midrst_count", 32'(count_a), 32'd0);
        chk("midrst_level", 32'(level_a), 32'd0);
        chk("midrst_pulse", 32'(pulse_a), 32'd0);
        chk("midrst_ovf",   32'(ovf_a),   32'd0);
        push(0, 0, 1, 1'b0);
        tick(7);
        chk("midrst_count_e6", 32'(count_a[1:0]), 32'd0);
        tick(1);
        chk("midrst_count_e7", 32'(count_a[1:0]), 32'd1);
        trig_a[0] = 1'b0;
        tick(12);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deb_count_n.md
DEB_COUNT_N -- requirements
Module: deb_count_n

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of independent trigger channels (range 1..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning the per-channel count width in bits (range 2..32).
REQ-003 SHALL have parameter DEB_CYCLES, default 16, meaning the consecutive stable synced samples needed to accept a level change (range 1..65535).
REQ-004 SHALL have parameter EDGE_MODE, default 0, selecting the counted edge: 0 = rising, 1 = falling, 2 = both.
REQ-005 SHALL have port clock  input  1  meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-007 SHALL have port trigger  input  N_CH  meaning raw asynchronous bounce-prone inputs, one per channel.
REQ-008 SHALL have port en  input  1  meaning global count enable; when low, accepted edges are not counted.
REQ-009 SHALL have port clr  input  N_CH  meaning per-channel synchronous count clear.
REQ-010 SHALL have port count  output  N_CH*WIDTH  meaning the flattened counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port level  output  N_CH  meaning the debounced stable level per channel.
REQ-012 SHALL have port pulse  output  N_CH  meaning a one-cycle strobe per accepted counted edge.
REQ-013 SHALL have port ovf  output  N_CH  meaning a sticky per-channel overflow flag.

Function
REQ-014 SHALL pass each trigger bit through a 2-flop synchronizer before any other use.
REQ-015 SHALL keep, per channel, a stable level plus a run counter sized $clog2(DEB_CYCLES+1).
- Synced sample == stable: run counter is cleared to 0.
- Synced sample != stable: run counter increments; on the increment reaching DEB_CYCLES, stable flips and the run counter clears.
REQ-016 SHALL ignore glitches: any run of differing samples shorter than DEB_CYCLES leaves level unchanged.
REQ-017 SHALL assert pulse[i] for exactly one cycle, the cycle after level[i] makes a transition selected by EDGE_MODE.
REQ-018 SHALL register pulse[i] regardless of en.
REQ-019 SHALL increment count[i] by 1 on the edge where pulse[i]=1 and en=1.
- Total latency: trigger held stable from sampling edge 0 -> count updated at edge DEB_CYCLES+3.
REQ-020 SHALL make clr[i] zero count[i] and ovf[i] on the next edge; clr wins over a simultaneous increment (that increment is lost).
REQ-021 SHALL, without saturation, wrap count[i] from 2^WIDTH-1 to 0 and set ovf[i] on that same edge.
REQ-022 SHALL hold ovf[i] until clr[i] or reset.
REQ-023 SHALL keep channels fully independent; simultaneous edges on all channels each count.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, clear synchronizers, run counters, level, pulse, count and ovf to 0.
REQ-025 SHALL treat reset as having priority over clr, en and trigger activity.
REQ-026 SHALL, after reset mid-debounce, require a full DEB_CYCLES stable run from the first post-reset sample.
REQ-027 SHALL NOT produce a pulse from the post-reset level=0 state alone, even if trigger is already high.
- The high level is later accepted per REQ-015 and counts as a rising edge.

Configuration
REQ-028 SHALL support macro DEB_COUNT_N_SAT_EN.
- Defined: count[i] saturates at 2^WIDTH-1; an increment attempted at max leaves count unchanged and sets ovf[i].
- Undefined: wrap behaviour per REQ-021.

Structure
REQ-029 SHALL place the EDGE_MODE encodings (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2) and default parameter constants in package deb_count_pkg.
REQ-030 SHALL implement synchronizer, run counter, level and edge detect as sub-module deb_filter, instantiated N_CH times via generate.
- The counter and ovf logic remain in the top level.

Verification
REQ-031 SHALL cover bounce rejection: DEB_CYCLES=4; trigger[0] toggles every 2 cycles for 40 cycles, then held high -> exactly one pulse[0]; count[0]=1 at edge 7 after hold start.
REQ-032 SHALL cover edge modes: EDGE_MODE=2; 5 clean high/low periods of 50 cycles -> count[0]=10; EDGE_MODE=1 -> count[0]=5.
REQ-033 SHALL cover wrap and saturation: WIDTH=2; 5 clean rising edges -> count=1 and ovf=1 without the macro; count=3 and ovf=1 with DEB_COUNT_N_SAT_EN.
REQ-034 SHALL cover clear collision: clr[1] asserted on the same edge as the count increment -> count[1]=0, ovf[1]=0; other channels unaffected.
REQ-035 SHALL cover enable gating: en=0 during 3 accepted edges -> 3 pulses, count unchanged; en=1 -> counting resumes.
REQ-036 SHALL cover mid-debounce reset: reset pulsed 2 cycles before acceptance -> all outputs 0; count=1 only after a further DEB_CYCLES+3 stable cycles.
